// File: rtl/tone_detect_pkg.sv
// Shared constants, FSM state type and helpers for the Goertzel tone detector.
package tone_detect_pkg;

  localparam int unsigned QSHIFT = 14;
  localparam int unsigned SEXT_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_ADD  = 2'd2,
    ST_OUT  = 2'd3
  } pwr_state_e;

  // Sign-extend the low w bits of x to SEXT_W bits.
  function automatic logic signed [SEXT_W-1:0] sext(input logic [SEXT_W-1:0] x,
                                                    input int unsigned w);
    logic signed [SEXT_W-1:0] t;
    t = signed'(x << (SEXT_W - w));
    return t >>> (SEXT_W - w);
  endfunction

endpackage

// File: rtl/tone_detect_if.sv
// Sample stream in, block power result out.
interface tone_detect_if #(
  parameter int unsigned DW = 14,
  parameter int unsigned AW = 32
);
  logic                 din_valid;
  logic signed [DW-1:0] din;
  logic                 pow_valid;
  logic [2*AW-1:0]      pow;
  logic                 det;
  logic                 busy;

  modport master (output din_valid, din, input pow_valid, pow, det, busy);
  modport slave  (input din_valid, din, output pow_valid, pow, det, busy);
endinterface

// File: rtl/goertzel_power.sv
// Three-step power pipeline: p1^2 + p2^2 - coef*p1*p2, clamped at zero.
module goertzel_power
  import tone_detect_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned CW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 start,
  input  logic signed [AW-1:0] p1,
  input  logic signed [AW-1:0] p2,
  input  logic signed [CW-1:0] pc,
  input  logic [2*AW-1:0]      thresh,
  output logic                 pow_valid,
  output logic [2*AW-1:0]      pow,
  output logic                 det,
  output logic                 busy
);

  localparam int unsigned PW = 2 * AW;
  localparam int unsigned MW = AW + CW;
  localparam int unsigned SW = 2 * AW + 2;

  pwr_state_e state, state_nxt;

  logic signed [AW-1:0] p1_q, p2_q, m_q;
  logic signed [CW-1:0] pc_q;
  logic signed [PW-1:0] a_q, b_q, c_q;
  logic signed [SW-1:0] sum_q;
  logic signed [MW-1:0] pm;
  logic signed [SW-1:0] r;
  logic [PW-1:0]        pow_nxt;
  logic                 fire;
  logic                 busy_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_MUL;
      ST_MUL:  state_nxt = ST_ADD;
      ST_ADD:  state_nxt = ST_OUT;
      ST_OUT:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (clr) state_nxt = ST_IDLE;
  end

  always_comb begin
    pm       = MW'(pc_q) * MW'(p1_q);
    r        = sum_q - SW'(c_q);
    pow_nxt  = r[SW-1] ? '0 : PW'(r);
    fire     = (state == ST_OUT) && !clr;
    busy_nxt = (state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p1_q      <= '0;
      p2_q      <= '0;
      pc_q      <= '0;
      m_q       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      sum_q     <= '0;
      pow_valid <= 1'b0;
      pow       <= '0;
      det       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (start) begin
        p1_q <= p1;
        p2_q <= p2;
        pc_q <= pc;
      end
      if (state == ST_MUL) begin
        a_q <= PW'(p1_q) * PW'(p1_q);
        b_q <= PW'(p2_q) * PW'(p2_q);
        m_q <= AW'(pm >>> QSHIFT);
      end
      if (state == ST_ADD) begin
        c_q   <= PW'(m_q) * PW'(p2_q);
        sum_q <= SW'(a_q) + SW'(b_q);
      end
      pow_valid <= fire;
      if (fire) begin
        pow <= pow_nxt;
        det <= pow_nxt > thresh;
      end
      busy <= busy_nxt;
    end
  end

endmodule

// File: rtl/tone_detect.sv
// Goertzel single-bin tone detector: per-sample recurrence, block counter and restart.
module tone_detect
  import tone_detect_pkg::*;
#(
  parameter int unsigned DW = 14,
  parameter int unsigned CW = 16,
  parameter int unsigned AW = 32,
  parameter int unsigned N  = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic signed [CW-1:0] coef,
  input  logic [2*AW-1:0]      thresh,
  tone_detect_if.slave         bus
);

  localparam int unsigned CNTW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned MW   = AW + CW;

  logic [CNTW-1:0]      cnt;
  logic signed [AW-1:0] s1, s2, s0, din_ext;
  logic signed [CW-1:0] coef_q, coef_use;
  logic signed [MW-1:0] prod;
  logic                 accept, last, start;

  // First sample of a block uses the live coefficient; the rest use the latched one.
  always_comb begin
    accept   = bus.din_valid && !clr;
    last     = (cnt == CNTW'(N - 1));
    start    = accept && last;
    coef_use = (cnt == '0) ? coef : coef_q;
    din_ext  = AW'(sext(SEXT_W'($unsigned(bus.din)), DW));
    prod     = MW'(coef_use) * MW'(s1);
    s0       = din_ext + AW'(prod >>> QSHIFT) - s2;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      s1     <= '0;
      s2     <= '0;
      coef_q <= '0;
    end else if (clr) begin
      cnt <= '0;
      s1  <= '0;
      s2  <= '0;
    end else if (bus.din_valid) begin
      if (cnt == '0) coef_q <= coef;
      if (last) begin
        cnt <= '0;
        s1  <= '0;
        s2  <= '0;
      end else begin
        cnt <= cnt + CNTW'(1);
        s2  <= s1;
        s1  <= s0;
      end
    end
  end

  goertzel_power #(
    .AW(AW),
    .CW(CW)
  ) u_power (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .start     (start),
    .p1        (s0),
    .p2        (s1),
    .pc        (coef_q),
    .thresh    (thresh),
    .pow_valid (bus.pow_valid),
    .pow       (bus.pow),
    .det       (bus.det),
    .busy      (bus.busy)
  );

endmodule

// File: tb/tb_tone_detect.sv
// Directed and random stimulus for tone_detect against a block-level Goertzel model.
module tb_tone_detect;

  localparam int unsigned N  = 64;
  localparam int unsigned DW = 14;
  localparam int unsigned CW = 16;
  localparam int unsigned AW = 32;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 clr;
  logic signed [CW-1:0] coef;
  logic [63:0]          thresh;

  tone_detect_if #(.DW(DW), .AW(AW)) bus ();

  tone_detect #(.DW(DW), .CW(CW), .AW(AW), .N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .coef   (coef),
    .thresh (thresh),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int                   n_err = 0;
  int                   n_chk = 0;
  int                   q[$];
  logic signed [CW-1:0] blk_coef;
  int                   pend;
  logic [63:0]          pend_pow;
  logic [63:0]          exp_pow;
  logic                 exp_det;
  bit                   fire;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint w32(input longint v);
    logic signed [31:0] t;
    t = 32'(v);
    return longint'(t);
  endfunction

  // Whole-block Goertzel power from the sample list and the block coefficient.
  function automatic logic [63:0] model_power(input int smp[$], input logic signed [15:0] c);
    longint s0, s1, s2, p1, p2, m;
    logic signed [127:0] r;
    s0 = 0; s1 = 0; s2 = 0; p2 = 0;
    foreach (smp[i]) begin
      p2 = s1;
      s0 = w32(longint'(smp[i]) + ((longint'(c) * s1) >>> 14) - s2);
      s2 = s1;
      s1 = s0;
    end
    p1 = s0;
    m  = w32((longint'(c) * p1) >>> 14);
    r  = 128'(p1) * 128'(p1) + 128'(p2) * 128'(p2) - 128'(m) * 128'(p2);
    return (r < 0) ? 64'd0 : r[63:0];
  endfunction

  function automatic int cosv(input int n);
    case (n % 4)
      0:       return 1000;
      2:       return -1000;
      default: return 0;
    endcase
  endfunction

  // Advance one clock, update the model with what was driven, then check all outputs.
  task automatic tick();
    @(posedge clk);
    fire = 1'b0;
    if (clr) begin
      pend = 0;
      q.delete();
    end else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          fire    = 1'b1;
          exp_pow = pend_pow;
          exp_det = pend_pow > thresh;
        end
      end
      if (bus.din_valid) begin
        if (q.size() == 0) blk_coef = coef;
        q.push_back(int'(bus.din));
        if (q.size() == int'(N)) begin
          pend_pow = model_power(q, blk_coef);
          q.delete();
          pend = 3;
        end
      end
    end
    #1;
    chk("pow_valid", 64'(bus.pow_valid), 64'(fire));
    chk("busy", 64'(bus.busy), 64'(pend > 0));
    chk("pow", bus.pow, exp_pow);
    chk("det", 64'(bus.det), 64'(exp_det));
  endtask

  task automatic drive(input bit v, input int x, input bit c);
    bus.din_valid = v;
    bus.din       = DW'(x);
    clr           = c;
    tick();
  endtask

  initial begin
    rst           = 1'b0;
    clr           = 1'b0;
    coef          = '0;
    thresh        = 64'd1000000000;
    bus.din_valid = 1'b0;
    bus.din       = '0;
    pend          = 0;
    exp_pow       = '0;
    exp_det       = 1'b0;
    blk_coef      = '0;
    pend_pow      = '0;

    #12;
    chk("rst_pow_valid", 64'(bus.pow_valid), 64'd0);
    chk("rst_pow", bus.pow, 64'd0);
    chk("rst_det", 64'(bus.det), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Zero input block
    for (int i = 0; i < int'(N); i++) drive(1'b1, 0, 1'b0);
    repeat (5) drive(1'b0, 0, 1'b0);
    chk("zero_pow", bus.pow, 64'd0);
    chk("zero_det", 64'(bus.det), 64'd0);

    // Impulse
    for (int i = 0; i < int'(N); i++) drive(1'b1, (i == 0) ? 1000 : 0, 1'b0);
    repeat (5) drive(1'b0, 0, 1'b0);
    chk("impulse_pow", bus.pow, 64'd1000000);

    // Three back-to-back on-bin blocks with continuous valid
    for (int i = 0; i < 3 * int'(N); i++) drive(1'b1, cosv(i), 1'b0);
    repeat (5) drive(1'b0, 0, 1'b0);
    chk("cos_pow", bus.pow, 64'd1024000000);
    chk("cos_det", 64'(bus.det), 64'd1);

    // Off-bin coefficient, then a mid-block coefficient change
    coef = 16'sd23170;
    for (int i = 0; i < int'(N); i++) drive(1'b1, cosv(i), 1'b0);
    for (int i = 0; i < int'(N); i++) begin
      if (i == 20) coef = '0;
      drive(1'b1, cosv(i), 1'b0);
    end
    repeat (5) drive(1'b0, 0, 1'b0);
    chk("bin8_det", 64'(bus.det), 64'd0);
    for (int i = 0; i < int'(N); i++) drive(1'b1, cosv(i), 1'b0);
    repeat (5) drive(1'b0, 0, 1'b0);
    chk("coef_next_blk", bus.pow, 64'd1024000000);

    // clr mid-block together with a valid sample, then a clean block
    for (int i = 0; i < 30; i++) drive(1'b1, 4000, 1'b0);
    drive(1'b1, 5000, 1'b1);
    for (int i = 0; i < int'(N); i++) drive(1'b1, cosv(i), 1'b0);
    repeat (5) drive(1'b0, 0, 1'b0);
    chk("clr_next_blk", bus.pow, 64'd1024000000);

    // clr while the power computation is in flight
    coef = 16'sd23170;
    for (int i = 0; i < int'(N); i++) drive(1'b1, cosv(i), 1'b0);
    drive(1'b0, 0, 1'b1);
    repeat (5) drive(1'b0, 0, 1'b0);
    chk("clr_busy_pow_hold", bus.pow, 64'd1024000000);

    // Random samples, gaps, coefficients, thresholds and occasional clr
    for (int b = 0; b < 8; b++) begin
      coef   = CW'($urandom);
      thresh = (64'($urandom_range(0, 15)) << 32) | 64'($urandom);
      repeat (90) begin
        drive(bit'($urandom_range(0, 3) != 0),
              int'($urandom_range(0, 16383)) - 8192,
              bit'($urandom_range(0, 60) == 0));
      end
    end
    repeat (5) drive(1'b0, 0, 1'b0);

    // Async reset while in the MUL step
    coef   = '0;
    thresh = 64'd1000000000;
    drive(1'b0, 0, 1'b1);
    for (int i = 0; i < int'(N); i++) drive(1'b1, cosv(i), 1'b0);
    repeat (5) drive(1'b0, 0, 1'b0);
    chk("pre_rst_pow", bus.pow, 64'd1024000000);
    for (int i = 0; i < int'(N); i++) drive(1'b1, cosv(i), 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_pow_valid", 64'(bus.pow_valid), 64'd0);
    chk("arst_pow", bus.pow, 64'd0);
    chk("arst_det", 64'(bus.det), 64'd0);
    chk("arst_busy", 64'(bus.busy), 64'd0);
    bus.din_valid = 1'b0;
    clr           = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst     = 1'b1;
    pend    = 0;
    q.delete();
    exp_pow = '0;
    exp_det = 1'b0;
    repeat (6) drive(1'b0, 0, 1'b0);
    for (int i = 0; i < int'(N); i++) drive(1'b1, cosv(i), 1'b0);
    repeat (5) drive(1'b0, 0, 1'b0);
    chk("post_rst_pow", bus.pow, 64'd1024000000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
